wb_port_arbiter: RTL

- Writer side of the register file's single write port (AD3/WE3/WD3).
- Merges two writeback sources into one registered write stream: the ALU path, which cannot be back-pressured, and the load/store unit (LSU) path, which uses a valid/ready handshake.
- LSU results that lose arbitration wait in a small FIFO.
- Exports a pending-write mask so the hazard unit can stall decode on registers with queued writes.

---
 rtl/wb_port_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges the ALU and LSU writeback streams onto one registered port.
// LSU results that lose arbitration are queued, and queued writes are exported as a pending-register mask.
module wb_port_arbiter #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  logic [4:0]    alu_rd,
    input  logic [31:0]   alu_data,
    input  logic          lsu_valid,
    output logic          lsu_ready,
    input  logic [4:0]    lsu_rd,
    input  logic [31:0]   lsu_data,
    output logic          WE3,
    output logic [4:0]    AD3,
    output logic [31:0]   WD3,
    output logic [31:0]   pending,
    output logic [CW-1:0] fifo_count
);

    localparam int            PW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [4:0]       slot_rd   [DEPTH];
    logic [31:0]      slot_data [DEPTH];
    logic [DEPTH-1:0] slot_live;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic alu_win;
    logic fifo_empty;
    logic lsu_xfer;
    logic bypass;
    logic enq;
    logic enq_live;
    logic deq;
    logic head_live;

    assign lsu_ready  = !rst && (count < FULL_COUNT);
    assign fifo_count = count;

    assign alu_win    = alu_valid && (alu_rd != 5'd0);
    assign fifo_empty = (count == '0);
    assign lsu_xfer   = lsu_valid && lsu_ready;
    assign deq        = !alu_win && !fifo_empty;
    assign bypass     = !alu_win && fifo_empty && lsu_xfer && (lsu_rd != 5'd0);
    assign enq        = lsu_xfer && (lsu_rd != 5'd0) && !bypass;
    // A same-cycle LSU result to the ALU's target is older, so it is stored already dead.
    assign enq_live   = !(alu_win && (lsu_rd == alu_rd));
    assign head_live  = slot_live[head];

    always_ff @(posedge clk) begin
        if (enq) begin
            slot_rd[tail]   <= lsu_rd;
            slot_data[tail] <= lsu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            slot_live <= '0;
            WE3       <= 1'b0;
            AD3       <= 5'd0;
            WD3       <= 32'd0;
        end else begin
            // The younger ALU write supersedes every queued LSU write to the same register.
            if (alu_win) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (slot_live[i] && (slot_rd[i] == alu_rd)) begin
                        slot_live[i] <= 1'b0;
                    end
                end
            end

            if (deq) begin
                slot_live[head] <= 1'b0;
                head            <= head + PW'(1);
            end

            if (enq) begin
                slot_live[tail] <= enq_live;
                tail            <= tail + PW'(1);
            end

            unique case ({enq, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (alu_win) begin
                WE3 <= 1'b1;
                AD3 <= alu_rd;
                WD3 <= alu_data;
            end else if (deq) begin
                WE3 <= head_live;
                if (head_live) begin
                    AD3 <= slot_rd[head];
                    WD3 <= slot_data[head];
                end
            end else if (bypass) begin
                WE3 <= 1'b1;
                AD3 <= lsu_rd;
                WD3 <= lsu_data;
            end else begin
                WE3 <= 1'b0;
            end
        end
    end

    always_comb begin
        pending = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_live[i]) begin
                pending[slot_rd[i]] = 1'b1;
            end
        end
        pending[0] = 1'b0;
    end

endmodule
